// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Avalon-style memory port between the instruction
// fetch requester and the load/store data requester. Round-robin on ties,
// honours waitrequest, returns read data with a one-cycle ack, and raises a
// sticky bus_error when a transaction stalls past TIMEOUT_CYCLES wait cycles.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        clk,
    input  logic        reset,
    // fetch requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    // load/store requester
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    // memory bus
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    // status
    output logic        busy,
    output logic        bus_error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BUS_I = 3'd1;
    localparam logic [2:0] S_BUS_D = 3'd2;
    localparam logic [2:0] S_ACK_I = 3'd3;
    localparam logic [2:0] S_ACK_D = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]       state_q,          state_d;
    logic             last_grant_q,     last_grant_d;
    logic [CNT_W-1:0] cnt_q,            cnt_d;
    logic [31:0]      avm_address_q,    avm_address_d;
    logic             avm_read_q,       avm_read_d;
    logic             avm_write_q,      avm_write_d;
    logic [31:0]      avm_writedata_q,  avm_writedata_d;
    logic [3:0]       avm_byteenable_q, avm_byteenable_d;
    logic             i_ack_q,          i_ack_d;
    logic             d_ack_q,          d_ack_d;
    logic [31:0]      i_rdata_q,        i_rdata_d;
    logic [31:0]      d_rdata_q,        d_rdata_d;
    logic             busy_q,           busy_d;
    logic             bus_error_q,      bus_error_d;

    logic             d_req;
    logic             grant_i;
    logic             grant_d;
    logic [CNT_W-1:0] cnt_inc;

    assign d_req   = d_read | d_write;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, grant selection, bus sequencing and timeout detection
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        cnt_d            = cnt_q;
        avm_address_d    = avm_address_q;
        avm_read_d       = avm_read_q;
        avm_write_d      = avm_write_q;
        avm_writedata_d  = avm_writedata_q;
        avm_byteenable_d = avm_byteenable_q;
        i_ack_d          = 1'b0;
        d_ack_d          = 1'b0;
        i_rdata_d        = i_rdata_q;
        d_rdata_d        = d_rdata_q;
        bus_error_d      = bus_error_q;
        grant_i          = 1'b0;
        grant_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                // fetch wins when alone or when data had the last grant
                grant_i = i_req & (~d_req | (last_grant_q == GRANT_D));
                grant_d = d_req & ~grant_i;
                if (grant_i) begin
                    state_d          = S_BUS_I;
                    last_grant_d     = GRANT_I;
                    cnt_d            = '0;
                    avm_address_d    = i_addr;
                    avm_byteenable_d = 4'b1111;
                    avm_writedata_d  = 32'h0;
                    avm_read_d       = 1'b1;
                    avm_write_d      = 1'b0;
                end else if (grant_d) begin
                    state_d          = S_BUS_D;
                    last_grant_d     = GRANT_D;
                    cnt_d            = '0;
                    avm_address_d    = d_addr;
                    avm_byteenable_d = d_byteenable;
                    avm_writedata_d  = d_writedata;
                    // a simultaneous read+write is treated as a write
                    avm_write_d      = d_write;
                    avm_read_d       = ~d_write;
                end
            end
            S_BUS_I, S_BUS_D: begin
                if (!avm_waitrequest) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    cnt_d       = '0;
                    if (state_q == S_BUS_I) begin
                        i_rdata_d = avm_readdata;
                        i_ack_d   = 1'b1;
                        state_d   = S_ACK_I;
                    end else begin
                        if (avm_read_q) begin
                            d_rdata_d = avm_readdata;
                        end
                        d_ack_d = 1'b1;
                        state_d = S_ACK_D;
                    end
                end else if (TIMEOUT_EN && (cnt_inc == CNT_LIMIT)) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = S_ERR;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_inc;
                end
            end
            S_ACK_I, S_ACK_D: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d     = S_ERR;
                avm_read_d  = 1'b0;
                avm_write_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            last_grant_q     <= GRANT_D;
            cnt_q            <= '0;
            avm_address_q    <= 32'h0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_writedata_q  <= 32'h0;
            avm_byteenable_q <= 4'h0;
            i_ack_q          <= 1'b0;
            d_ack_q          <= 1'b0;
            i_rdata_q        <= 32'h0;
            d_rdata_q        <= 32'h0;
            busy_q           <= 1'b0;
            bus_error_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            cnt_q            <= cnt_d;
            avm_address_q    <= avm_address_d;
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_byteenable_q <= avm_byteenable_d;
            i_ack_q          <= i_ack_d;
            d_ack_q          <= d_ack_d;
            i_rdata_q        <= i_rdata_d;
            d_rdata_q        <= d_rdata_d;
            busy_q           <= busy_d;
            bus_error_q      <= bus_error_d;
        end
    end

    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_byteenable = avm_byteenable_q;
    assign i_ack          = i_ack_q;
    assign d_ack          = d_ack_q;
    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign busy           = busy_q;
    assign bus_error      = bus_error_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single Avalon-style memory port between the instruction-fetch requester and the load/store data requester.
- Sequences each bus transaction and honours avm_waitrequest.
- Returns captured read data with a one-cycle ack pulse to the requester.
- Sits between the fetch/PC logic, the load/store path driven by MemRead/MemWrite, and the top-level memory interface. Includes a stuck-bus timeout that raises a sticky error.

Parameters:
- TIMEOUT_CYCLES, 1024, waitrequest-high cycles tolerated per transaction before error; 0 disables the timeout.
- CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request, level; held until i_ack
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle pulse, fetch complete
- i_rdata  out  32  fetched instruction word
- d_read  in  1  data read request, level
- d_write  in  1  data write request, level
- d_addr  in  32  data byte address
- d_writedata  in  32  store data
- d_byteenable  in  4  store/load byte lanes
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  32  load data
- avm_address  out  32  bus address
- avm_read  out  1  bus read strobe
- avm_write  out  1  bus write strobe
- avm_writedata  out  32  bus write data
- avm_byteenable  out  4  bus byte lanes
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  bus read data
- busy  out  1  high whenever state != IDLE
- bus_error  out  1  sticky timeout flag

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high) takes effect at the next edge:
  - state goes to IDLE.
  - All avm_* strobes, acks, i_rdata, d_rdata, avm_address, avm_writedata, avm_byteenable and bus_error clear to 0.
  - last_grant is set to DATA, so the first tie goes to fetch.
  - The timeout counter clears.
  - Reset mid-transaction abandons the transaction with no ack.
- States: IDLE, BUS_I, BUS_D, ACK_I, ACK_D, ERR.
- IDLE:
  - Samples i_req and d_req (d_req = d_read | d_write).
  - Only one request pending: grant it.
  - Both pending: grant the port opposite to last_grant (round-robin), then update last_grant.
  - On grant, latch address, byteenable and writedata into the avm_* registers. Fetch uses byteenable 4'b1111, read only.
  - Drive the strobe: avm_read for fetch or d_read; avm_write for d_write. If d_read and d_write are both high, the access is a write; d_rdata is unchanged.
  - Strobe rises on the edge that leaves IDLE, i.e. one cycle after a request is first seen.
- BUS_x:
  - avm_* held stable while avm_waitrequest=1; the timeout counter increments each such cycle.
  - Completion is the edge where a strobe is high and avm_waitrequest=0:
    - For a read, capture avm_readdata into i_rdata or d_rdata.
    - Drop the strobes, clear the counter, go to ACK_x.
  - Zero wait states gives exactly 1 BUS cycle.
- ACK_x:
  - i_ack or d_ack is high for exactly this cycle; the rdata output is valid from this cycle.
  - Next state is always IDLE; requests are ignored during ACK.
  - The requester drops or changes its request on the edge ending ACK.
  - Minimum transaction is 3 cycles (IDLE, BUS, ACK).
- Timeout:
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES while waitrequest is still high, deassert the strobes, set bus_error=1 and go to ERR.
  - ERR is terminal until reset: no grants, no acks, busy=1.
- i_rdata and d_rdata hold their value until the next completed read on the same port.
- Addresses pass through unchecked. Alignment is the requester's responsibility.
- Request changes while in BUS_x are ignored, because address and data are latched.

Test Plan:
- Fetch, zero wait: i_req=1, i_addr=0xBFC00000, avm_readdata=0x24020005, waitrequest=0.
  - avm_read high in cycle 1 with avm_address=0xBFC00000.
  - i_ack pulses in cycle 2 with i_rdata=0x24020005; busy low in cycle 3.
- Store with 3 wait states: d_write=1, d_addr=0x1000, d_writedata=0xDEADBEEF, be=4'b0011.
  - avm_write held for 4 cycles with stable bus values.
  - d_ack exactly once; d_rdata unchanged.
- Simultaneous requests after reset, both held continuously: grants alternate I, D, I, D; each ack occurs 3 cycles apart with zero wait.
- Timeout with TIMEOUT_CYCLES=8, waitrequest stuck high on a data read:
  - Strobe drops after 8 wait cycles; bus_error=1 and stays 1.
  - No d_ack; a later i_req is not granted until reset.
- Reset mid-transfer: reset asserted during BUS_D with waitrequest=1.
  - Next edge: avm_read=0, no d_ack, outputs zero.
  - The first tie after reset is granted to fetch.
- d_read=d_write=1: a write is issued (avm_read=0, avm_write=1); d_rdata keeps its prior value.
